// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: SLL, ROL, SRL, SRA by up to STEP bits per cycle.
// Valid/ready request and response handshakes; one operation in flight at a time.
module seq_shifter #(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP       = 4,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [SHAMT_W-1:0]    B,
    input  logic [1:0]            Shiftop,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // STEP may equal DATA_WIDTH, so compare in one extra bit
    localparam logic [SHAMT_W:0]   STEP_W = (SHAMT_W + 1)'(STEP);
    localparam logic [SHAMT_W:0]   DW_W   = (SHAMT_W + 1)'(DATA_WIDTH);
    localparam logic [SHAMT_W-1:0] STEP_K = STEP_W[SHAMT_W-1:0];

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0]      rem_q, rem_d;
    logic [1:0]              op_q, op_d;

    logic                    last_step;
    logic [SHAMT_W-1:0]      k;
    logic [DATA_WIDTH-1:0]   sll_w;
    logic [DATA_WIDTH-1:0]   srl_w;
    logic [DATA_WIDTH-1:0]   rol_w;
    logic signed [DATA_WIDTH-1:0] sra_w;
    logic [DATA_WIDTH-1:0]   step_res;

    assign last_step = ({1'b0, rem_q} <= STEP_W);
    assign k         = last_step ? rem_q : STEP_K;

    // Each op on its own net so SRA keeps signed semantics
    assign sll_w = work_q << k;
    assign srl_w = work_q >> k;
    assign sra_w = $signed(work_q) >>> k;
    assign rol_w = (work_q << k) | (work_q >> (DW_W - {1'b0, k}));

    always_comb begin
        step_res = work_q;
        unique case (op_q)
            OP_SLL:  step_res = sll_w;
            OP_ROL:  step_res = rol_w;
            OP_SRL:  step_res = srl_w;
            OP_SRA:  step_res = sra_w;
            default: step_res = work_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = A;
                    rem_d   = B;
                    op_d    = Shiftop;
                    state_d = (B == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                work_d = step_res;
                rem_d  = rem_q - k;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            op_q    <= OP_SLL;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign Result    = work_q;

    // A stalled response must not change until the consumer takes it
    a_done_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == DONE && !out_ready) |=> (state_q == DONE && $stable(work_q)));

    a_idle_hold: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && !in_valid) |=> (state_q == IDLE && $stable(work_q)));

    a_busy_rem: assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY) |-> (rem_q != '0));

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH  32  operand/result width; power of two, 8..64.
  STEP        4   maximum bit positions shifted per BUSY cycle; power of two, 1..DATA_WIDTH.
REQ-002 SHAMT_W SHALL be a derived localparam equal to $clog2(DATA_WIDTH).
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        input   1           single clock; all state changes on its rising edge.
  rst        input   1           asynchronous, active-high reset.
  in_valid   input   1           request valid.
  in_ready   output  1           block can accept a request.
  A          input   DATA_WIDTH  operand.
  B          input   SHAMT_W     shift amount, unsigned.
  Shiftop    input   2           00 SLL, 01 ROL, 10 SRL, 11 SRA.
  out_valid  output  1           Result valid.
  out_ready  input   1           consumer accepts Result.
  Result     output  DATA_WIDTH  shifted/rotated value.
  busy       output  1           high whenever state is not IDLE.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-005 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both SHALL be registered-state decodes.
REQ-006 Accept SHALL occur when in_valid && in_ready at a clock edge, which latches A into the working register, B into rem, and Shiftop into op.
REQ-007 On accept with B==0 the next state SHALL be DONE and Result SHALL equal A; on accept with B!=0 the next state SHALL be BUSY.
REQ-008 Each BUSY cycle SHALL apply op by k = min(rem, STEP) positions to the working register and then set rem = rem - k.
REQ-009 When rem <= STEP in BUSY, the next state SHALL be DONE; otherwise the FSM SHALL stay in BUSY.
REQ-010 Latency from the accept edge to out_valid SHALL be exactly max(1, ceil(B/STEP)) cycles.
REQ-011 Op semantics per step SHALL be:
  SLL: zero-fill from the LSB.
  SRL: zero-fill from the MSB.
  SRA: the MSB of the current working value replicates into vacated bits.
  ROL: bits leaving the MSB re-enter at the LSB.
REQ-012 The final Result SHALL equal the single-step operation by B modulo DATA_WIDTH, and SRA SHALL use signed semantics on the full width.
REQ-013 Per-op results SHALL be computed on separate nets before the op selection, so that signed SRA is never coerced to unsigned by mixing with unsigned operands.
REQ-014 In DONE, out_valid && out_ready SHALL return the FSM to IDLE on that edge.
REQ-015 While DONE && !out_ready, Result SHALL remain stable for any number of cycles.
REQ-016 in_valid SHALL be ignored outside IDLE, and A, B and Shiftop changes after accept SHALL have no effect on the current operation.
REQ-017 The block SHALL have no back-to-back pipelining: a new accept is possible no earlier than the cycle after DONE exits.
REQ-018 Result SHALL hold its last value in IDLE and SHALL update only during BUSY and accept.

Reset
REQ-019 Asserting rst SHALL take effect immediately, regardless of clk, from any state including mid-BUSY or DONE, with no further edges required.
REQ-020 During and after reset: state SHALL be IDLE, rem SHALL be 0, op SHALL be 00, Result SHALL be 0, out_valid SHALL be 0, in_ready SHALL be 1 and busy SHALL be 0.
REQ-021 An operation in flight at reset SHALL be discarded and SHALL produce no out_valid.

Verification
REQ-022 The bench SHALL cover the following scenarios with DATA_WIDTH=32 and STEP=4:
  V1: SLL, A=0x0000_0001, B=31 -> Result 0x8000_0000; out_valid 8 cycles after accept.
  V2: SRA, A=0x8000_0000, B=4 -> Result 0xF800_0000 after 1 cycle; SRL with the same inputs -> 0x0800_0000.
  V3: ROL, A=0x8000_0001, B=1 -> Result 0x0000_0003; ROL with B=0 -> Result 0x8000_0001 after 1 cycle.
  V4: SRL, A=0xFFFF_FFFF, B=17 -> Result 0x0000_7FFF after 5 cycles; repeat with STEP=1 -> 17 cycles.
  V5: After V1 completes, hold out_ready=0 for 5 cycles while driving in_valid=1 with new data -> Result stays 0x8000_0000, in_ready=0, the new request is not accepted, and on out_ready=1 the FSM goes to IDLE and the pending in_valid is then accepted.
  V6: Assert rst asynchronously 2 cycles into a B=31 SLL -> out_valid=0, busy=0, Result=0 immediately; after release, a fresh SRA, A=0xFFFF_FF00, B=8 -> Result 0xFFFF_FFFF.
REQ-023 The bench SHALL compare every response against the reference model A<<B, A>>B, $signed(A)>>>B, and rotate, over 10k random (A, B, Shiftop) vectors with random out_ready back-pressure.
